// File: rtl/control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : control_fsm
//  Description : Multicycle control unit for the single-issue datapath.
//                Sequences each instruction through FETCH, DECODE, EXECUTE,
//                MEM, WRITEBACK and PCUPDATE, drives the datapath strobes,
//                resolves BEQ/BNE and counts retired instructions.
//                Optional feature macro: ILLEGAL_TRAP_EN
//                  defined   : illegal instruction parks the FSM in HALT
//                  undefined : illegal instruction retires as a NOP
//  Revision    : 1.0 - initial release
// ============================================================================
module control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [3:0]       state,
  output logic             pcsrc,
  output logic             regwrite,
  output logic             alusrc,
  output logic [1:0]       aluop,
  output logic             memread,
  output logic             memwrite,
  output logic             memtoreg,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  // Opcode values of the supported instruction classes
  localparam logic [6:0] C_OP_R      = 7'b0110011;
  localparam logic [6:0] C_OP_IALU   = 7'b0010011;
  localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OP_STORE  = 7'b0100011;
  localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
  localparam logic [2:0] C_F3_BEQ    = 3'b000;
  localparam logic [2:0] C_F3_BNE    = 3'b001;

  // ALU operation encodings
  localparam logic [1:0] C_ALUOP_ADD   = 2'b00;
  localparam logic [1:0] C_ALUOP_SUB   = 2'b01;
  localparam logic [1:0] C_ALUOP_FUNCT = 2'b10;

  // Step encoding is visible on the state bus; the PC unit keys off 4'b1000
  typedef enum logic [3:0] {
    ST_FETCH     = 4'b0000,
    ST_DECODE    = 4'b0001,
    ST_EXECUTE   = 4'b0010,
    ST_MEM       = 4'b0011,
    ST_WRITEBACK = 4'b0100,
    ST_PCUPDATE  = 4'b1000,
    ST_HALT      = 4'b1111
  } state_e;

  // Instruction class captured at the end of FETCH; CL_NONE only after reset
  typedef enum logic [2:0] {
    CL_NONE  = 3'd0,
    CL_R     = 3'd1,
    CL_IALU  = 3'd2,
    CL_LOAD  = 3'd3,
    CL_STORE = 3'd4,
    CL_BEQ   = 3'd5,
    CL_BNE   = 3'd6,
    CL_ILL   = 3'd7
  } class_e;

  state_e           state_q,   state_d;
  class_e           class_q,   class_d;
  logic             zero_q,    zero_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  class_e           w_class_dec;
  logic             w_is_branch;
  logic             w_taken;

  // Classify the raw opcode/funct3; only consumed while in FETCH
  always_comb begin
    w_class_dec = CL_ILL;
    case (opcode)
      C_OP_R:      w_class_dec = CL_R;
      C_OP_IALU:   w_class_dec = CL_IALU;
      C_OP_LOAD:   w_class_dec = CL_LOAD;
      C_OP_STORE:  w_class_dec = CL_STORE;
      C_OP_BRANCH: begin
        if (funct3 == C_F3_BEQ) begin
          w_class_dec = CL_BEQ;
        end else if (funct3 == C_F3_BNE) begin
          w_class_dec = CL_BNE;
        end else begin
          w_class_dec = CL_ILL;
        end
      end
      default:     w_class_dec = CL_ILL;
    endcase
  end

  // Branch resolution uses the zero flag captured at the end of EXECUTE
  always_comb begin
    w_is_branch = (class_q == CL_BEQ) || (class_q == CL_BNE);
    w_taken     = ((class_q == CL_BEQ) &&  zero_q) ||
                  ((class_q == CL_BNE) && !zero_q);
  end

  // Next-state sequencing plus capture of class, zero flag and retire count
  always_comb begin
    state_d   = state_q;
    class_d   = class_q;
    zero_d    = zero_q;
    retired_d = retired_q;

    case (state_q)
      ST_FETCH: begin
        class_d = w_class_dec;
        state_d = ST_DECODE;
      end

      ST_DECODE: begin
        if (class_q == CL_ILL || class_q == CL_NONE) begin
`ifdef ILLEGAL_TRAP_EN
          state_d = ST_HALT;
`else
          // Illegal instruction retires as a NOP with pcsrc=0
          state_d = ST_PCUPDATE;
`endif
        end else begin
          state_d = ST_EXECUTE;
        end
      end

      ST_EXECUTE: begin
        zero_d = zero;
        case (class_q)
          CL_R, CL_IALU:     state_d = ST_WRITEBACK;
          CL_LOAD, CL_STORE: state_d = ST_MEM;
          default:           state_d = ST_PCUPDATE;
        endcase
      end

      ST_MEM: begin
        // Hold until the memory reports completion
        if (mem_ready) begin
          if (class_q == CL_LOAD) begin
            state_d = ST_WRITEBACK;
          end else begin
            state_d = ST_PCUPDATE;
          end
        end
      end

      ST_WRITEBACK: begin
        state_d = ST_PCUPDATE;
      end

      ST_PCUPDATE: begin
        // PCUPDATE is always a single cycle, so every edge here retires one
        retired_d = retired_q + CNT_W'(1);
        state_d   = ST_FETCH;
      end

      ST_HALT: begin
`ifdef ILLEGAL_TRAP_EN
        state_d = ST_HALT;
`else
        state_d = ST_FETCH;
`endif
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // State, captured class/zero and retire counter; reset aborts any step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      class_q   <= CL_NONE;
      zero_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      zero_q    <= zero_d;
      retired_q <= retired_d;
    end
  end

  // Moore strobes decoded from the current step and the captured class
  always_comb begin
    pcsrc    = 1'b0;
    regwrite = 1'b0;
    alusrc   = 1'b0;
    aluop    = C_ALUOP_ADD;
    memread  = 1'b0;
    memwrite = 1'b0;
    memtoreg = 1'b0;
    illegal  = 1'b0;

    case (state_q)
      ST_EXECUTE: begin
        alusrc = (class_q == CL_IALU) || (class_q == CL_LOAD) ||
                 (class_q == CL_STORE);
        if (class_q == CL_R || class_q == CL_IALU) begin
          aluop = C_ALUOP_FUNCT;
        end else if (w_is_branch) begin
          aluop = C_ALUOP_SUB;
        end else begin
          aluop = C_ALUOP_ADD;
        end
      end

      ST_MEM: begin
        memread  = (class_q == CL_LOAD);
        memwrite = (class_q == CL_STORE);
      end

      ST_WRITEBACK: begin
        regwrite = 1'b1;
        memtoreg = (class_q == CL_LOAD);
      end

      ST_PCUPDATE: begin
        pcsrc = w_taken;
      end

      ST_HALT: begin
`ifdef ILLEGAL_TRAP_EN
        illegal = 1'b1;
`else
        illegal = 1'b0;
`endif
      end

      default: begin
        pcsrc = 1'b0;
      end
    endcase
  end

  // Export the registered step and counter
  always_comb begin
    state   = state_q;
    retired = retired_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_control_fsm.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_control_fsm
//  Description : Scoreboard bench for control_fsm. Instruction traces are
//                derived from the instruction-class step lists and pushed as
//                expected cycles; a negedge monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_control_fsm;

  localparam int CW = 4;   // small counter so wrap-around is exercised

  localparam logic [3:0] S_FETCH = 4'b0000;
  localparam logic [3:0] S_DEC   = 4'b0001;
  localparam logic [3:0] S_EXEC  = 4'b0010;
  localparam logic [3:0] S_MEM   = 4'b0011;
  localparam logic [3:0] S_WB    = 4'b0100;
  localparam logic [3:0] S_PCU   = 4'b1000;
  localparam logic [3:0] S_HALT  = 4'b1111;

  localparam int K_R = 0, K_I = 1, K_LOAD = 2, K_STORE = 3,
                 K_BEQ = 4, K_BNE = 5, K_ILL = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [6:0]    opcode = '0;
  logic [2:0]    funct3 = '0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic [3:0]    state;
  logic          pcsrc, regwrite, alusrc, memread, memwrite, memtoreg, illegal;
  logic [1:0]    aluop;
  logic [CW-1:0] retired;

  control_fsm #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
    .zero(zero), .mem_ready(mem_ready), .state(state), .pcsrc(pcsrc),
    .regwrite(regwrite), .alusrc(alusrc), .aluop(aluop),
    .memread(memread), .memwrite(memwrite), .memtoreg(memtoreg),
    .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]    st;
    logic          pcsrc, regwrite, alusrc;
    logic [1:0]    aluop;
    logic          memread, memwrite, memtoreg, illegal;
    logic [CW-1:0] ret;
  } exp_t;

  exp_t          sb[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  bit            active   = 0;
  int            cyc      = 0;
  logic [CW-1:0] model_ret = '0;

  function automatic bit legal_op(input logic [6:0] o);
    return (o == 7'b0110011) || (o == 7'b0010011) || (o == 7'b0000011) ||
           (o == 7'b0100011) || (o == 7'b1100011);
  endfunction

  // Monitor: pop one expected cycle per clock and compare away from the edge
  always @(negedge clk) begin
    exp_t          e;
    logic [16:0]   ev, av;
    logic [1:0]    ea, aa;
    if (active && rst_n) begin
      cyc++;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty cycle %0d: DUT state %b with no expected entry", cyc, state);
      end else begin
        e  = sb.pop_front();
        // aluop is only meaningful while the ALU is operating
        ea = (e.st == S_EXEC) ? e.aluop : 2'b00;
        aa = (e.st == S_EXEC) ? aluop   : 2'b00;
        ev = {e.st, e.pcsrc, e.regwrite, e.alusrc, ea, e.memread,
              e.memwrite, e.memtoreg, e.illegal, e.ret};
        av = {state, pcsrc, regwrite, alusrc, aa, memread,
              memwrite, memtoreg, illegal, retired};
        if (av !== ev) begin
          n_fail++;
          $display("FAIL cycle_%0d {state,pcsrc,rw,asrc,aluop,mr,mw,m2r,ill,ret}: got %b_%b%b%b_%b_%b%b%b%b_%0d expected %b_%b%b%b_%b_%b%b%b%b_%0d",
                   cyc, state, pcsrc, regwrite, alusrc, aa, memread, memwrite, memtoreg, illegal, retired,
                   e.st, e.pcsrc, e.regwrite, e.alusrc, ea, e.memread, e.memwrite, e.memtoreg, e.illegal, e.ret);
        end
      end
    end
  end

  // Direct check of the reset-forced outputs
  task automatic check_reset(input string name);
    logic [16:0] av;
    av = {state, pcsrc, regwrite, alusrc, aluop, memread, memwrite,
          memtoreg, illegal, retired};
    n_checks++;
    if (av !== 17'd0) begin
      n_fail++;
      $display("FAIL %s: state=%b strobes/ret=%b expected all zero", name, state, av[12:0]);
    end
  endtask

  // Issue one instruction; its expected trace follows from its class rules.
  // Entered and left at posedge+1 of a FETCH cycle. rst_at >= 0 pulses reset
  // in that cycle of the trace instead of completing the instruction.
  task automatic run_instr(input int cls, input logic [6:0] opc,
                           input logic [2:0] f3, input int waits,
                           input logic z, input int rst_at);
    logic [3:0] seq[$];
    int         mem_idx;
    exp_t       e;
    seq.push_back(S_FETCH);
    seq.push_back(S_DEC);
    if (cls == K_ILL) begin
`ifdef ILLEGAL_TRAP_EN
      for (int k = 0; k < 10; k++) seq.push_back(S_HALT);
`else
      seq.push_back(S_PCU);
`endif
    end else begin
      seq.push_back(S_EXEC);
      if (cls == K_LOAD || cls == K_STORE)
        for (int k = 0; k <= waits; k++) seq.push_back(S_MEM);
      if (cls == K_R || cls == K_I || cls == K_LOAD) seq.push_back(S_WB);
      seq.push_back(S_PCU);
    end
    mem_idx = 0;
    for (int i = 0; i < seq.size(); i++) begin
      if (i == rst_at) begin
        #2 rst_n = 1'b0;
        #1 check_reset("async_reset_mid_instr");
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_ret = '0;
        return;
      end
      opcode = (i == 0) ? opc : ((i == 1) ? 7'b0000000 : 7'($urandom));
      funct3 = (i == 0) ? f3 : 3'($urandom);
      zero   = (seq[i] == S_EXEC) ? z : 1'($urandom);
      if (seq[i] == S_MEM) begin
        mem_ready = (mem_idx == waits);
        mem_idx++;
      end else begin
        mem_ready = 1'($urandom);
      end
      e.st       = seq[i];
      e.regwrite = (seq[i] == S_WB);
      e.memtoreg = (seq[i] == S_WB) && (cls == K_LOAD);
      e.alusrc   = (seq[i] == S_EXEC) && (cls == K_I || cls == K_LOAD || cls == K_STORE);
      e.aluop    = (cls == K_R || cls == K_I) ? 2'b10 :
                   ((cls == K_BEQ || cls == K_BNE) ? 2'b01 : 2'b00);
      e.memread  = (seq[i] == S_MEM) && (cls == K_LOAD);
      e.memwrite = (seq[i] == S_MEM) && (cls == K_STORE);
      e.pcsrc    = (seq[i] == S_PCU) &&
                   ((cls == K_BEQ && z) || (cls == K_BNE && !z));
      e.illegal  = (seq[i] == S_HALT);
      e.ret      = model_ret;
      sb.push_back(e);
      if (seq[i] == S_PCU) model_ret++;
      @(posedge clk);
      #1;
    end
`ifdef ILLEGAL_TRAP_EN
    if (cls == K_ILL) begin
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      model_ret = '0;
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         cls, waits;
    logic [6:0] opc;
    logic [2:0] f3;
    logic       z;

    #1 rst_n = 1'b0;
    #1 check_reset("reset_state");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    active = 1;

    // Directed cases
    run_instr(K_R,     7'b0110011, 3'b000, 0, 1'b0, -1);  // ADD
    run_instr(K_LOAD,  7'b0000011, 3'b010, 3, 1'b0, -1);  // LW, 3 wait cycles
    run_instr(K_BEQ,   7'b1100011, 3'b000, 0, 1'b1, -1);  // BEQ taken
    run_instr(K_BNE,   7'b1100011, 3'b001, 0, 1'b1, -1);  // BNE not taken
    run_instr(K_BNE,   7'b1100011, 3'b001, 0, 1'b0, -1);  // BNE taken
    run_instr(K_ILL,   7'b1111111, 3'b000, 0, 1'b0, -1);  // illegal opcode
    run_instr(K_STORE, 7'b0100011, 3'b010, 3, 1'b0,  5);  // SW, reset in MEM wait
    run_instr(K_STORE, 7'b0100011, 3'b010, 1, 1'b0, -1);  // SW completes
    run_instr(K_I,     7'b0010011, 3'b101, 0, 1'b1, -1);  // I-ALU

    // Randomized instruction stream
    for (int n = 0; n < 40; n++) begin
      cls   = $urandom_range(0, 6);
      waits = $urandom_range(0, 3);
      z     = 1'($urandom);
      f3    = 3'($urandom);
      case (cls)
        K_R:     opc = 7'b0110011;
        K_I:     opc = 7'b0010011;
        K_LOAD:  opc = 7'b0000011;
        K_STORE: opc = 7'b0100011;
        K_BEQ:   begin opc = 7'b1100011; f3 = 3'b000; end
        K_BNE:   begin opc = 7'b1100011; f3 = 3'b001; end
        default: begin
          if ($urandom_range(0, 1) == 1) begin
            opc = 7'b1100011;
            f3  = 3'($urandom_range(2, 7));
          end else begin
            opc = 7'($urandom);
            while (legal_op(opc)) opc = 7'($urandom);
          end
        end
      endcase
      run_instr(cls, opc, f3, waits, z, -1);
    end

    active = 0;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
